ula_muldiv_seq: RTL and testbench
=================================

// Module: ula_muldiv_seq
// PURPOSE
//  Multi-cycle unsigned multiply/divide sequencer for the EX stage of the RISC-V pipeline.
//  Accepts one op from the ID/EX register and iterates a single XLEN-bit add/sub datapath
//  (one conditional add or subtract per cycle) until the result is ready.
//  Hands the result to EX/MEM through a valid/ready handshake and raises busy for the hazard unit.
// PARAMETERS
//  XLEN   64   operand/result width
//  CNT_W  7    iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
//  clk         in   1     rising-edge clock
//  rst_n       in   1     synchronous reset, active-low
//  in_valid    in   1     op request present
//  in_ready    out  1     sequencer can accept an op
//  in_op       in   2     0=MUL (low XLEN), 1=MULHU (high XLEN), 2=DIVU, 3=REMU
//  operand1    in   XLEN  multiplicand / dividend
//  operand2    in   XLEN  multiplier / divisor
//  flush       in   1     pipeline flush; kills the in-flight op
//  busy        out  1     op accepted and result not yet consumed
//  out_valid   out  1     result valid
//  out_ready   in   1     consumer takes result
//  result      out  XLEN  selected result
//  flag        out  2     [0]=result==0, [1]=result[XLEN-1]; both valid while out_valid=1
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=0 during reset cycle then 1,
//   busy=0, out_valid=0, result=0, flag=0, counter=0. Overrides all other inputs.
//  States: IDLE, RUN, DONE.
//  IDLE: in_ready=1. in_valid=1 (flush=0) -> latch op/operands, clear acc, cnt=0, go RUN.
//   DIVU/REMU with operand2==0 -> skip RUN, go DONE next cycle:
//   DIVU result={XLEN{1}}, REMU result=operand1 (RISC-V semantics).
//  RUN: in_ready=0, busy=1. One iteration per cycle, XLEN cycles total (cnt 0..XLEN-1).
//   MUL/MULHU: 2*XLEN product reg {hi,lo}; lo holds multiplier. If lo[0], hi+=multiplicand
//    (XLEN+1-bit add, carry kept); then shift {carry,hi,lo} right 1.
//   DIVU/REMU: restoring. {rem,quo} shift left 1; trial=rem-divisor (XLEN+1 bits);
//    if trial non-negative rem=trial, quo[0]=1, else quo[0]=0.
//   At cnt==XLEN-1 -> DONE, out_valid=1 next cycle.
//  DONE: out_valid=1, busy=1, result/flag held stable until out_ready=1.
//   out_valid&&out_ready -> IDLE next cycle (no back-to-back accept in same cycle).
//  Latency: accept edge at cycle 0 -> out_valid high at cycle XLEN+1; div-by-zero: cycle 1.
//  Result select: MUL=lo, MULHU=hi, DIVU=quo, REMU=rem. All arithmetic unsigned, mod 2**XLEN.
//  flush=1: any state -> IDLE next cycle, out_valid=0, busy=0, result discarded;
//   flush and in_valid together in IDLE -> op NOT accepted.
//  Operand changes on in_* after accept have no effect (latched copies only).
//  Reset mid-RUN or mid-DONE: identical to power-on reset; no result emitted.
//  out_ready ignored outside DONE; in_valid ignored outside IDLE.
// TESTING
//  MUL 7*6, XLEN=64 -> out_valid at cycle 65, result=42, flag=2'b00.
//  MULHU 0xFFFF_FFFF_FFFF_FFFF*2 -> result=1; MUL same operands -> 0xFFFF_FFFF_FFFF_FFFE, flag[1]=1.
//  DIVU 100/7 -> result=14; REMU 100/7 -> result=2; REMU 21/7 -> result=0, flag[0]=1.
//  DIVU 5/0 -> out_valid at cycle 1, result=all ones; REMU 5/0 -> result=5.
//  Hold out_ready=0 10 cycles in DONE -> result stable, in_ready=0, busy=1; then accept.
//  flush at RUN cycle 30 -> IDLE next cycle, out_valid never rises; rst_n=0 mid-RUN -> all outputs reset.

Source files
------------

// File: rtl/ula_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer for the EX stage.
// One shared (XLEN+2)-bit add/sub per cycle; the result is handed off over a valid/ready pair.
module ula_muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      flag,
  output logic [1:0]      dbg_state
);

  // Handshake: an op transfers on a rising edge where in_valid && in_ready && !flush;
  // a result transfers on a rising edge where out_valid && out_ready.
  // Producers must hold their payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W2 = XLEN + 2;

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand or divisor
  logic [XLEN-1:0] hi_q;     // product high half or partial remainder
  logic [XLEN-1:0] lo_q;     // multiplier bits or quotient bits
  logic [CNT_W-1:0] cnt;

  logic            is_mul;
  logic [XLEN:0]   rem_sh;
  logic [W2-1:0]   add_a;
  logic [W2-1:0]   add_b;
  logic            add_cin;
  logic [W2-1:0]   sum;
  logic            trial_neg;
  logic [XLEN-1:0] hi_n;
  logic [XLEN-1:0] lo_n;
  logic [XLEN-1:0] fin_res;
  logic [XLEN-1:0] dz_res;
  logic            accept;
  logic            div_zero;

  assign is_mul    = ~op_q[1];
  assign rem_sh    = {hi_q, lo_q[XLEN-1]};
  assign dbg_state = state;

  // Shared datapath: multiply adds the gated multiplicand, divide subtracts the divisor
  // from the shifted remainder via inverted operand plus carry-in.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (is_mul) begin
      add_a = {2'b00, hi_q};
      add_b = lo_q[0] ? {2'b00, opnd_q} : '0;
    end else begin
      add_a   = {1'b0, rem_sh};
      add_b   = ~{2'b00, opnd_q};
      add_cin = 1'b1;
    end
  end

  assign sum       = add_a + add_b + W2'(add_cin);
  assign trial_neg = sum[W2-1];

  always_comb begin
    hi_n = hi_q;
    lo_n = lo_q;
    if (is_mul) begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_n = trial_neg ? rem_sh[XLEN-1:0] : sum[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ~trial_neg};
    end
  end

  // MULHU and REMU live in the high register, MUL and DIVU in the low one.
  assign fin_res  = op_q[0] ? hi_n : lo_n;
  assign dz_res   = in_op[0] ? operand1 : '1;
  assign accept   = in_valid && in_ready;
  assign div_zero = in_op[1] && (operand2 == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flag      <= '0;
      cnt       <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flag      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            op_q     <= in_op;
            opnd_q   <= operand2;
            hi_q     <= '0;
            lo_q     <= operand1;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (div_zero) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= dz_res;
              flag      <= {dz_res[XLEN-1], dz_res == '0};
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= fin_res;
            flag      <= {fin_res[XLEN-1], fin_res == '0};
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_muldiv_seq.sv
// Bench for ula_muldiv_seq: directed table, handshake/flush/reset corner sequences,
// and randomized ops checked against a plain-arithmetic reference model.
module tb_ula_muldiv_seq;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            flush;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [1:0]      flag;
  logic [1:0]      dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  ula_muldiv_seq #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .operand1  (operand1),
    .operand2  (operand2),
    .flush     (flush),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag      (flag),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    case (op)
      2'd0:    return p[63:0];
      2'd1:    return p[127:64];
      2'd2:    return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready(input string nm);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Issue one op, check latency, result, flag and the DONE hold behaviour, then consume.
  task automatic do_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int exp_lat, input int hold, input string nm);
    int lat;
    logic [63:0] exp_res;
    exp_q.push_back(ref_model(op, a, b));
    wait_in_ready(nm);
    in_valid = 1'b1;
    in_op    = op;
    operand1 = a;
    operand2 = b;
    tick();
    operand1 = {$urandom, $urandom};
    operand2 = {$urandom, $urandom};
    in_op    = 2'($urandom_range(0, 3));
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_res = exp_q.pop_front();
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " result"}, result, exp_res);
    chk({nm, " flag"}, 64'(flag), {62'd0, exp_res[63], exp_res == 64'd0});
    chk({nm, " busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk($sformatf("%s hold%0d result", nm, i), result, exp_res);
      chk($sformatf("%s hold%0d out_valid", nm, i), 64'(out_valid), 64'd1);
      chk($sformatf("%s hold%0d in_ready", nm, i), 64'(in_ready), 64'd0);
      chk($sformatf("%s hold%0d busy", nm, i), 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " out_valid drop"}, 64'(out_valid), 64'd0);
    chk({nm, " busy drop"}, 64'(busy), 64'd0);
  endtask

  task automatic watch_quiet(input int n, input string nm);
    bit rose;
    rose = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (out_valid) rose = 1'b1;
    end
    chk(nm, 64'(rose), 64'd0);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    wait_in_ready("start");
    in_valid = 1'b1;
    in_op    = op;
    operand1 = a;
    operand2 = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{2'd0, 64'd7, 64'd6, 64'd42, 65};
    tbl[1]  = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65};
    tbl[2]  = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    tbl[3]  = '{2'd2, 64'd100, 64'd7, 64'd14, 65};
    tbl[4]  = '{2'd3, 64'd100, 64'd7, 64'd2, 65};
    tbl[5]  = '{2'd3, 64'd21, 64'd7, 64'd0, 65};
    tbl[6]  = '{2'd2, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    tbl[7]  = '{2'd3, 64'd5, 64'd0, 64'd5, 1};
    tbl[8]  = '{2'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'h4000_0000_0000_0000, 65};
    tbl[9]  = '{2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 65};
    tbl[10] = '{2'd2, 64'd0, 64'd3, 64'd0, 65};
    tbl[11] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65};

    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; operand1 = '0; operand2 = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset flag", 64'(flag), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post-reset in_ready", 64'(in_ready), 64'd1);

    // Directed table: table-held expectations, with the model cross-checked against it.
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("model vs tbl%0d", i), ref_model(tbl[i].op, tbl[i].a, tbl[i].b), tbl[i].res);
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat, 1, $sformatf("tbl%0d", i));
    end

    // Result held across a 10-cycle stall in DONE.
    do_op(2'd0, 64'd7, 64'd6, 65, 10, "stall");

    // Flush mid-RUN: idle next cycle, no result ever.
    start_op(2'd0, 64'd123, 64'd456);
    repeat (29) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush run out_valid", 64'(out_valid), 64'd0);
    chk("flush run busy", 64'(busy), 64'd0);
    chk("flush run in_ready", 64'(in_ready), 64'd1);
    watch_quiet(80, "flush run no result");

    // flush together with in_valid in IDLE: not accepted.
    in_valid = 1'b1; in_op = 2'd2; operand1 = 64'd9; operand2 = 64'd0; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush+valid busy", 64'(busy), 64'd0);
    watch_quiet(5, "flush+valid no result");

    // Flush while in DONE discards the result.
    start_op(2'd3, 64'd77, 64'd0);
    chk("dz done out_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush done out_valid", 64'(out_valid), 64'd0);
    chk("flush done busy", 64'(busy), 64'd0);

    // Reset mid-RUN behaves like power-on reset.
    start_op(2'd2, 64'd1000, 64'd3);
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    chk("midrun reset in_ready", 64'(in_ready), 64'd0);
    chk("midrun reset busy", 64'(busy), 64'd0);
    chk("midrun reset out_valid", 64'(out_valid), 64'd0);
    chk("midrun reset result", result, 64'd0);
    chk("midrun reset flag", 64'(flag), 64'd0);
    rst_n = 1'b1;
    watch_quiet(80, "midrun reset no result");

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [63:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 20));
        2:       b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 5) == 0) a = 64'($urandom_range(0, 50));
      do_op(op, a, b, (op[1] && b == 64'd0) ? 1 : 65, $urandom_range(0, 2),
            $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
